pmem_arbiter: RTL and testbench
===============================

Name: pmem_arbiter

Overview:
- Two-master arbiter and sequencer in front of the single DPI-backed physical memory port.
- Shares the memory between IFU (instruction fetch, read-only) and LSU (load/store, read/write) using valid/ready request and response handshakes.
- Issues exactly one memory access per accepted request, so DPI read/write side effects happen once.
- Adds a configurable response latency so the core pipeline can be exercised against non-zero memory delay.

Parameters:
LATENCY, 1, cycles from memory access cycle to response cycle; legal range 1..15
RR_EN, 1, 1 = round-robin on tie; 0 = fixed LSU priority

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
ifu_req_valid  input  1  IFU request valid
ifu_req_ready  output  1  IFU request accepted this cycle
ifu_addr  input  32  IFU fetch address
ifu_resp_valid  output  1  IFU response valid
ifu_resp_ready  input  1  IFU consumes response
ifu_rdata  output  32  fetched word
lsu_req_valid  input  1  LSU request valid
lsu_req_ready  output  1  LSU request accepted this cycle
lsu_addr  input  32  LSU address, used for both read and write
lsu_wen  input  1  1 = write request
lsu_wdata  input  32  write data
lsu_wmask  input  8  byte write mask
lsu_resp_valid  output  1  LSU response valid
lsu_resp_ready  input  1  LSU consumes response
lsu_rdata  output  32  load data; 0 for write requests
mem_valid  output  1  memory access strobe
mem_raddr  output  32  memory read address
mem_rdata  input  32  memory read data, combinational
mem_wen  output  1  memory write enable
mem_waddr  output  32  memory write address
mem_wdata  output  32  memory write data
mem_wmask  output  8  memory write mask

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. Latched request registers: owner (IFU/LSU), addr, wen, wdata, wmask. Also a 4-bit countdown, last_grant, and rdata_q.
- Reset (rst high at a posedge):
  - state becomes IDLE; last_grant becomes IFU; countdown and rdata_q become 0.
  - All outputs are 0 from the next cycle.
  - An in-flight request is dropped with no response.
  - If reset hits during ISSUE, that cycle's memory access has already occurred; this is accepted behaviour.
- IDLE:
  - Only one master gets ready high per cycle.
  - Only IFU valid: ifu_req_ready = 1.
  - Only LSU valid: lsu_req_ready = 1.
  - Both valid: RR_EN=1 grants the master that is not last_grant; RR_EN=0 grants LSU.
  - ready depends combinationally on valid; requesters must not make valid depend on ready.
  - On handshake (valid && ready): latch the request, update last_grant, go to ISSUE.
  - IFU requests are latched with wen = 0.
- ISSUE (exactly 1 cycle):
  - mem_valid = 1 and mem_raddr = latched addr.
  - mem_wen = latched wen; mem_waddr, mem_wdata, mem_wmask = latched values.
  - rdata_q captures mem_rdata for reads; rdata_q = 0 for writes.
  - Countdown loads LATENCY-1. Go to RESP if LATENCY==1, otherwise WAIT.
- WAIT: decrement the countdown; go to RESP when it reaches 0.
- RESP:
  - The owner's resp_valid = 1 and its rdata = rdata_q, held stable until the owner's resp_ready.
  - On resp_valid && resp_ready, go to IDLE. No new request is accepted in the same cycle.
- mem_valid, mem_wen and every mem_* data output are 0 outside ISSUE. There are no repeat accesses while the state is stalled.
- Timing: request accepted at edge T means mem access in cycle T+1, and resp_valid first at cycle T+1+LATENCY. With resp_ready held high, throughput is 1 request per LATENCY+2 cycles.
- The non-owning master's resp_valid stays 0 throughout.
- Request inputs are ignored outside IDLE; ready stays 0 in all other states.

Decomposition:
- Package pmem_arb_pkg holds:
  - state enum (IDLE/ISSUE/WAIT/RESP);
  - master ID constants (MST_IFU=0, MST_LSU=1);
  - ADDR_W=32, DATA_W=32, MASK_W=8.
- Sub-module arb_rr2 is the 2-way picker: inputs req[1:0], last, rr_en; output one-hot grant. It is combinational. last_grant is held in the arbiter.

Test Plan:
- Reset with both valids high -> all outputs 0 during reset. After release with RR_EN=1, the first grant is LSU (last_grant=IFU).
- IFU read at 0x80000000, LATENCY=1, memory returns 0x00000413 -> mem_valid high exactly 1 cycle at T+1; ifu_resp_valid at T+2 with ifu_rdata=0x00000413.
- LSU write addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F -> single cycle with mem_wen=1 and those values; lsu_rdata=0 at response; memory model logs exactly one write.
- Both valid continuously, RR_EN=1, LATENCY=3 -> grants alternate LSU, IFU, LSU, IFU. Each response arrives 4 cycles after accept. With RR_EN=0, the grant is LSU every time.
- resp_ready held low 5 cycles in RESP -> resp_valid and rdata stable for all 5 cycles, mem_valid stays 0, the other master is not granted.
- rst asserted during WAIT -> no response ever appears; state is IDLE the next cycle; a new request is accepted normally.

Source files
------------

// File: rtl/pmem_arb_pkg.sv
// Shared types and constants for the physical-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pmem_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = 8;

    // Master IDs double as bit positions in the picker's req/grant vectors.
    localparam logic MST_IFU = 1'b0;
    localparam logic MST_LSU = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    // One latched memory request.
    typedef struct packed {
        logic              owner;
        logic [ADDR_W-1:0] addr;
        logic              wen;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] wmask;
    } req_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way request picker: one-hot grant, round-robin on tie or fixed LSU priority.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether a grant becomes a handshake.
// Ports: req[1:0] (bit index = master ID), last = master granted most recently,
//        rr_en = 1 for round-robin tie-break, grant[1:0] one-hot (or zero).
module arb_rr2
    import pmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       rr_en,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
            2'b11: begin
                // On a tie, round-robin favours whoever did not win last time;
                // otherwise LSU always wins so loads/stores never starve behind fetch.
                if (rr_en && last == MST_LSU) grant = 2'b01;
                else                          grant = 2'b10;
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/pmem_arbiter.sv
// Shares one physical memory port between IFU (read-only) and LSU (read/write).
// Latency: accept at edge T -> memory access in cycle T+1 -> response from cycle T+1+LATENCY.
// Backpressure: one request in flight; ready is low until the response is consumed.
// Ports: ifu_req_* / lsu_req_* request handshakes, ifu_resp_* / lsu_resp_* response
//        handshakes, mem_* single-cycle access strobe and data toward the memory model
//        (mem_rdata is returned combinationally). clk with synchronous active-high rst.
module pmem_arbiter
    import pmem_arb_pkg::*;
#(
    parameter int LATENCY = 1,      // legal range 1..15
    parameter bit RR_EN   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    input  logic              ifu_resp_ready,
    output logic [DATA_W-1:0] ifu_rdata,

    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [MASK_W-1:0] lsu_wmask,
    output logic              lsu_resp_valid,
    input  logic              lsu_resp_ready,
    output logic [DATA_W-1:0] lsu_rdata,

    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask
);

    state_t            state_q, state_d;
    req_t              req_q, req_d;
    logic [3:0]        cnt_q;
    logic              last_grant_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        grant;

    arb_rr2 u_pick (
        .req   ({lsu_req_valid, ifu_req_valid}),
        .last  (last_grant_q),
        .rr_en (RR_EN),
        .grant (grant)
    );

    // Request as it will be latched if the picker's choice handshakes this cycle.
    // Fetches are always reads and carry no write payload.
    always_comb begin
        req_d.owner = grant[MST_LSU] ? MST_LSU : MST_IFU;
        req_d.addr  = grant[MST_LSU] ? lsu_addr : ifu_addr;
        req_d.wen   = grant[MST_LSU] & lsu_wen;
        req_d.wdata = grant[MST_LSU] ? lsu_wdata : '0;
        req_d.wmask = grant[MST_LSU] ? lsu_wmask : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        mem_valid      = 1'b0;
        mem_raddr      = '0;
        mem_wen        = 1'b0;
        mem_waddr      = '0;
        mem_wdata      = '0;
        mem_wmask      = '0;
        ifu_resp_valid = 1'b0;
        ifu_rdata      = '0;
        lsu_resp_valid = 1'b0;
        lsu_rdata      = '0;
        unique case (state_q)
            IDLE: begin
                // Ready is masked by rst so nothing is accepted while reset is held.
                ifu_req_ready = ~rst & grant[MST_IFU];
                lsu_req_ready = ~rst & grant[MST_LSU];
                if (!rst && grant != 2'b00) state_d = ISSUE;
            end
            ISSUE: begin
                // The only cycle the memory sees the access, so DPI side effects happen once.
                mem_valid = 1'b1;
                mem_raddr = req_q.addr;
                mem_wen   = req_q.wen;
                mem_waddr = req_q.addr;
                mem_wdata = req_q.wdata;
                mem_wmask = req_q.wmask;
                state_d   = (LATENCY == 1) ? RESP : WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd1) state_d = RESP;
            end
            RESP: begin
                if (req_q.owner == MST_IFU) begin
                    ifu_resp_valid = 1'b1;
                    ifu_rdata      = rdata_q;
                    if (ifu_resp_ready) state_d = IDLE;
                end else begin
                    lsu_resp_valid = 1'b1;
                    lsu_rdata      = rdata_q;
                    if (lsu_resp_ready) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q        <= '0;
            last_grant_q <= MST_IFU;
            cnt_q        <= '0;
            rdata_q      <= '0;
        end else begin
            if (ifu_req_ready || lsu_req_ready) begin
                req_q        <= req_d;
                last_grant_q <= req_d.owner;
            end
            if (state_q == ISSUE) begin
                rdata_q <= req_q.wen ? '0 : mem_rdata;
                cnt_q   <= 4'(LATENCY - 1);
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench: three arbiter configurations, each with its own stimulus and
// transaction-level model (a pending access tracked by accept cycle and phase).
// Latency/backpressure: n/a (bench).
module tb_pmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    localparam int          END_CYC = 2500;
    localparam logic [31:0] RD_KEY  = 32'h80000413;

    // Memory contents as seen by reads: address-derived, so 0x80000000 reads 0x00000413.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        return a ^ RD_KEY;
    endfunction

    task automatic chk32(input int cfg, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cfg%0d %s: got %h, want %h at %0t", cfg, nm, act, exp, $time);
        end
    endtask

    task automatic chkb(input int cfg, input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cfg%0d %s: got %b, want %b at %0t", cfg, nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int LAT     = (g == 0) ? 1 : (g == 1) ? 3 : 15;
        localparam bit RR      = (g != 2);
        localparam int SEG_BEG = 3;
        localparam int SEG_END = SEG_BEG + 6 * (LAT + 2);

        logic        rst;
        logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
        logic [31:0] ifu_addr, ifu_rdata;
        logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
        logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
        logic [7:0]  lsu_wmask;
        logic        mem_valid, mem_wen;
        logic [31:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata;
        logic [7:0]  mem_wmask;

        assign mem_rdata = memfn(mem_raddr);

        pmem_arbiter #(.LATENCY(LAT), .RR_EN(RR)) dut (
            .clk            (clk),
            .rst            (rst),
            .ifu_req_valid  (ifu_req_valid),
            .ifu_req_ready  (ifu_req_ready),
            .ifu_addr       (ifu_addr),
            .ifu_resp_valid (ifu_resp_valid),
            .ifu_resp_ready (ifu_resp_ready),
            .ifu_rdata      (ifu_rdata),
            .lsu_req_valid  (lsu_req_valid),
            .lsu_req_ready  (lsu_req_ready),
            .lsu_addr       (lsu_addr),
            .lsu_wen        (lsu_wen),
            .lsu_wdata      (lsu_wdata),
            .lsu_wmask      (lsu_wmask),
            .lsu_resp_valid (lsu_resp_valid),
            .lsu_resp_ready (lsu_resp_ready),
            .lsu_rdata      (lsu_rdata),
            .mem_valid      (mem_valid),
            .mem_raddr      (mem_raddr),
            .mem_rdata      (mem_rdata),
            .mem_wen        (mem_wen),
            .mem_waddr      (mem_waddr),
            .mem_wdata      (mem_wdata),
            .mem_wmask      (mem_wmask)
        );

        // Model: at most one outstanding access; phase = cycles since its accept edge.
        int          cyc = 0;
        bit          known = 0;
        bit          busy = 0;
        int          own = 0;
        int          acc = 0;
        int          last = 0;
        logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
        bit          m_wen = 0;
        logic [7:0]  m_wmask = '0;
        int          wr_model = 0, wr_seen = 0;
        int          ng = 0, prev_pick = 0, stall = 0;

        initial begin
            rst            = 1'b1;
            ifu_req_valid  = 1'b1;
            ifu_addr       = 32'h80000000;
            ifu_resp_ready = 1'b1;
            lsu_req_valid  = 1'b1;
            lsu_addr       = 32'h80001000;
            lsu_wen        = 1'b1;
            lsu_wdata      = 32'hDEADBEEF;
            lsu_wmask      = 8'h0F;
            lsu_resp_ready = 1'b1;
            while (cyc < END_CYC) begin
                int         ph;
                logic [1:0] pick;
                bit         iss, rsp, rsp_i, rsp_l, hs_i, hs_l, rsp_hs, rst_s;
                @(negedge clk);
                ph   = cyc - acc;
                pick = 2'b00;
                if (!busy && !rst) begin
                    if (ifu_req_valid && lsu_req_valid) pick = (!RR || last == 0) ? 2'b10 : 2'b01;
                    else                                pick = {lsu_req_valid, ifu_req_valid};
                end
                iss   = busy && ph == 1;
                rsp   = busy && ph >= 1 + LAT;
                rsp_i = rsp && own == 0;
                rsp_l = rsp && own == 1;
                if (known) begin
                    chkb(g, "ifu_req_ready", ifu_req_ready, pick[0]);
                    chkb(g, "lsu_req_ready", lsu_req_ready, pick[1]);
                    chkb(g, "mem_valid", mem_valid, iss);
                    chk32(g, "mem_raddr", mem_raddr, iss ? m_addr : 32'd0);
                    chkb(g, "mem_wen", mem_wen, iss && m_wen);
                    chk32(g, "mem_waddr", mem_waddr, iss ? m_addr : 32'd0);
                    chk32(g, "mem_wdata", mem_wdata, iss ? m_wdata : 32'd0);
                    chk32(g, "mem_wmask", {24'd0, mem_wmask}, iss ? {24'd0, m_wmask} : 32'd0);
                    chkb(g, "ifu_resp_valid", ifu_resp_valid, rsp_i);
                    chk32(g, "ifu_rdata", ifu_rdata, rsp_i ? m_rdata : 32'd0);
                    chkb(g, "lsu_resp_valid", lsu_resp_valid, rsp_l);
                    chk32(g, "lsu_rdata", lsu_rdata, rsp_l ? m_rdata : 32'd0);
                    if (iss && m_wen) wr_model++;
                    if (mem_valid && mem_wen) wr_seen++;
                end
                // Hand-computed expectations for the back-to-back segment after reset.
                if (known && cyc >= SEG_BEG && cyc < SEG_END) begin
                    if (pick != 2'b00) begin
                        chkb(g, "seg_grant_lsu", lsu_req_ready, (!RR || ng % 2 == 0));
                        if (ng > 0) chk32(g, "seg_accept_gap", cyc - prev_pick, LAT + 2);
                        prev_pick = cyc;
                        ng++;
                    end
                    if (rsp_i) chk32(g, "seg_fetch_word", ifu_rdata, 32'h00000413);
                    if (rsp_l) chk32(g, "seg_store_rdata", lsu_rdata, 32'h00000000);
                    if (iss && m_wen) begin
                        chk32(g, "seg_store_addr", mem_waddr, 32'h80001000);
                        chk32(g, "seg_store_data", mem_wdata, 32'hDEADBEEF);
                        chk32(g, "seg_store_mask", {24'd0, mem_wmask}, 32'h0000000F);
                    end
                end
                hs_i   = pick[0];
                hs_l   = pick[1];
                rsp_hs = rsp && (own == 0 ? ifu_resp_ready : lsu_resp_ready);
                rst_s  = rst;

                @(posedge clk);
                if (rst_s) begin
                    busy  = 0;
                    last  = 0;
                    known = 1;
                end else if (rsp_hs) begin
                    busy = 0;
                end else if (hs_i || hs_l) begin
                    busy    = 1;
                    acc     = cyc;
                    own     = hs_l ? 1 : 0;
                    last    = own;
                    m_addr  = hs_l ? lsu_addr : ifu_addr;
                    m_wen   = hs_l && lsu_wen;
                    m_wdata = hs_l ? lsu_wdata : 32'd0;
                    m_wmask = hs_l ? lsu_wmask : 8'd0;
                    m_rdata = m_wen ? 32'd0 : memfn(m_addr);
                end
                cyc++;

                #1;
                if (cyc < SEG_END) begin
                    // Both masters keep the same request pending, responses always taken.
                    rst = (cyc < SEG_BEG);
                end else begin
                    rst = ($urandom_range(0, 99) < 2);
                    if (!ifu_req_valid || hs_i) begin
                        ifu_req_valid = ($urandom_range(0, 99) < 60);
                        ifu_addr      = $urandom;
                    end
                    if (!lsu_req_valid || hs_l) begin
                        lsu_req_valid = ($urandom_range(0, 99) < 60);
                        lsu_addr      = $urandom;
                        lsu_wen       = 1'($urandom_range(0, 1));
                        lsu_wdata     = $urandom;
                        lsu_wmask     = 8'($urandom_range(0, 255));
                    end
                    if (stall > 0) begin
                        stall--;
                        ifu_resp_ready = 1'b0;
                        lsu_resp_ready = 1'b0;
                    end else if ($urandom_range(0, 9) == 0) begin
                        stall          = int'($urandom_range(4, 7));
                        ifu_resp_ready = 1'b0;
                        lsu_resp_ready = 1'b0;
                    end else begin
                        ifu_resp_ready = ($urandom_range(0, 3) != 0);
                        lsu_resp_ready = ($urandom_range(0, 3) != 0);
                    end
                end
            end
            chk32(g, "write_count", wr_seen, wr_model);
        end
    end

    initial begin
        repeat (END_CYC + 20) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
